// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the OpenMIPS general-purpose register file.
// Holds the bus widths and the active levels of reset, write enable and read enable.
package regfile_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port of the register file.
// Priority: reset -> $0 -> write-back bypass -> enabled array read -> zero.
// The bypass branch exists only when REGFILE_WB_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_NUM_LOG2
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] word,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

`ifndef REGFILE_WB_BYPASS_EN
  // Without forwarding the write-side inputs have no effect on this port.
  logic unused_bypass;
  assign unused_bypass = ^{we, waddr, wdata};
`endif

  // Priority mux; the $0 branch comes first so the bypass never sees address 0.
  always_comb begin
    rdata = '0;
    if (rst == RST_ENABLE) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
`ifdef REGFILE_WB_BYPASS_EN
    end else if ((we == WRITE_ENABLE) && (waddr == raddr) && (re == READ_ENABLE)) begin
      rdata = wdata;
`endif
    end else if (re == READ_ENABLE) begin
      rdata = word;
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit OpenMIPS register file, one write port, two read ports.
// Asynchronous active-low reset clears every entry; $0 is hard-wired zero.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle write data to the reads.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W       = REG_BUS_W,
  parameter int REG_NUM      = regfile_pkg::REG_NUM,
  parameter int REG_NUM_LOG2 = regfile_pkg::REG_NUM_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_NUM_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re1,
  input  logic [REG_NUM_LOG2-1:0] raddr1,
  output logic [DATA_W-1:0]       rdata1,
  input  logic                    re2,
  input  logic [REG_NUM_LOG2-1:0] raddr2,
  output logic [DATA_W-1:0]       rdata2
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [DATA_W-1:0] word1;
  logic [DATA_W-1:0] word2;

  // $0 has no storage at all.
  assign regs[0] = '0;

  for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    // Each entry clears on reset and loads wdata when it is the write target.
    always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
        q_reg <= '0;
      end else if ((we == WRITE_ENABLE) && (waddr == REG_NUM_LOG2'(gi))) begin
        q_reg <= wdata;
      end
    end

    assign regs[gi] = q_reg;
  end

  assign word1 = regs[raddr1];
  assign word2 = regs[raddr2];

  // Two identical port instances keep both read paths behaviourally the same.
  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_NUM_LOG2)
  ) u_rdport1 (
    .rst   (rst),
    .re    (re1),
    .raddr (raddr1),
    .word  (word1),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata1)
  );

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_NUM_LOG2)
  ) u_rdport2 (
    .rst   (rst),
    .re    (re2),
    .raddr (raddr2),
    .word  (word2),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for the register file. Expected read data is
// pushed when a transaction is driven and popped when the outputs are sampled.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
  } txn_t;

  logic [31:0] mdl [32];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  int checks = 0;
  int failures = 0;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  // Reference read of one port given the current inputs and the model array.
  function automatic logic [31:0] model_read(input logic r, input logic [4:0] a);
    if (rst !== 1'b1) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (we === 1'b1 && waddr == a && r === 1'b1) return wdata;
`endif
    if (r === 1'b1) return mdl[a];
    return 32'h0;
  endfunction

  // Drive a transaction after the falling edge and queue its expected reads.
  task automatic apply(input txn_t t);
    @(negedge clk);
    we = t.we; waddr = t.waddr; wdata = t.wdata;
    re1 = t.re1; raddr1 = t.raddr1; re2 = t.re2; raddr2 = t.raddr2;
    #1;
    q1.push_back(model_read(re1, raddr1));
    q2.push_back(model_read(re2, raddr2));
  endtask

  // Advance to the rising edge and commit the write into the model.
  task automatic edge_update();
    @(posedge clk);
    if (rst === 1'b1 && we === 1'b1 && waddr != 5'd0) mdl[waddr] = wdata;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_reset();
    txn_t t;
    logic [31:0] e1, e2;
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    checks += 2;
    $display("[reset] rst=0 rd1=%h rd2=%h", rdata1, rdata2);
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_init_rd1 got=%h exp=%h", rdata1, 32'h0); end
    if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_init_rd2 got=%h exp=%h", rdata2, 32'h0); end
    @(negedge clk);
    #3 rst = 1'b1;
    t = '{1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0};
    apply(t);
    void'(q1.pop_front()); void'(q2.pop_front());
    edge_update();
    t = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5};
    apply(t);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    checks += 2;
    $display("[reset] preload r5 rd1=%h rd2=%h", rdata1, rdata2);
    if (rdata1 !== e1) begin failures++; $display("FAIL preload_rd1 got=%h exp=%h", rdata1, e1); end
    if (rdata2 !== e2) begin failures++; $display("FAIL preload_rd2 got=%h exp=%h", rdata2, e2); end
    // Assert reset between edges; outputs must clear with no clock edge.
    #2 rst = 1'b0;
    clear_model();
    #1;
    q1.push_back(model_read(re1, raddr1));
    q2.push_back(model_read(re2, raddr2));
    e1 = q1.pop_front(); e2 = q2.pop_front();
    checks += 2;
    $display("[reset] async assert rd1=%h rd2=%h", rdata1, rdata2);
    if (rdata1 !== e1) begin failures++; $display("FAIL async_rd1 got=%h exp=%h", rdata1, e1); end
    if (rdata2 !== e2) begin failures++; $display("FAIL async_rd2 got=%h exp=%h", rdata2, e2); end
    // A write attempted during reset must be ignored.
    we = 1'b1; waddr = 5'd6; wdata = 32'hCAFE_F00D;
    edge_update();
    @(negedge clk);
    we = 1'b0;
    #3 rst = 1'b1;
    t = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6};
    apply(t);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    checks += 2;
    $display("[reset] after release r5=%h r6=%h", rdata1, rdata2);
    if (rdata1 !== e1) begin failures++; $display("FAIL release_r5 got=%h exp=%h", rdata1, e1); end
    if (rdata2 !== e2) begin failures++; $display("FAIL release_r6 got=%h exp=%h", rdata2, e2); end
    edge_update();
  endtask

  // Run a directed table: one transaction per cycle, both ports compared.
  task automatic run_table(input string name, input txn_t tab[$]);
    logic [31:0] e1, e2;
    foreach (tab[i]) begin
      apply(tab[i]);
      e1 = q1.pop_front(); e2 = q2.pop_front();
      checks += 2;
      $display("[%s] #%0d we=%b wa=%0d wd=%h re1=%b ra1=%0d rd1=%h re2=%b ra2=%0d rd2=%h",
               name, i, we, waddr, wdata, re1, raddr1, rdata1, re2, raddr2, rdata2);
      if (rdata1 !== e1) begin failures++; $display("FAIL %s_rd1 #%0d got=%h exp=%h", name, i, rdata1, e1); end
      if (rdata2 !== e2) begin failures++; $display("FAIL %s_rd2 #%0d got=%h exp=%h", name, i, rdata2, e2); end
      edge_update();
    end
  endtask

  task automatic test_basic();
    txn_t tab[$];
    tab = '{'{1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3},
            '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 5'd3}};
    run_table("basic", tab);
  endtask

  task automatic test_zero();
    txn_t tab[$];
    tab = '{'{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0}};
    run_table("zero", tab);
  endtask

  task automatic test_hazard();
    txn_t tab[$];
    tab = '{'{1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0},
            '{1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 1'b1, 5'd7},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7}};
    run_table("hazard", tab);
  endtask

  task automatic test_dual();
    txn_t tab[$];
    tab = '{'{1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0},
            '{1'b1, 5'd31, 32'hB, 1'b0, 5'd0, 1'b0, 5'd0},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd1},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd31}};
    run_table("dual", tab);
  endtask

  task automatic test_back_to_back();
    txn_t tab[$];
    tab = '{'{1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 1'b1, 5'd9},
            '{1'b1, 5'd9, 32'd2, 1'b1, 5'd9, 1'b1, 5'd9},
            '{1'b1, 5'd9, 32'd3, 1'b1, 5'd9, 1'b1, 5'd9},
            '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9}};
    run_table("b2b", tab);
  endtask

  task automatic test_random();
    txn_t tab[$];
    txn_t t;
    for (int i = 0; i < 1000; i++) begin
      t.we = 1'($urandom_range(0, 1));
      t.waddr = 5'($urandom_range(0, 31));
      t.wdata = $urandom;
      t.re1 = 1'($urandom_range(0, 1));
      t.re2 = 1'($urandom_range(0, 1));
      t.raddr1 = ($urandom_range(0, 3) == 0) ? t.waddr : 5'($urandom_range(0, 31));
      t.raddr2 = ($urandom_range(0, 3) == 0) ? t.waddr : 5'($urandom_range(0, 31));
      tab.push_back(t);
    end
    run_table("rand", tab);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_zero();
    test_hazard();
    test_dual();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
